qconv_tile_scheduler: RTL and testbench

- Sequences the quantized-convolution state engine (qconv_states) over a full layer.
- Latches a per-layer tile/output-channel configuration when the host starts a layer.
- Issues one single-cycle start pulse to the engine per (tile_y, tile_x, oc_high) job and waits for the engine's finish before issuing the next job.
- Drives the current job indices to the address generators, reports busy/done/error to the host controller, and guards against a hung engine with a watchdog.

---
 rtl/qconv_tile_scheduler.sv | 168 ++++++++++++++++
 tb/tb_qconv_tile_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qconv_tile_scheduler.sv
// Layer-level job sequencer for the qconv engine: walks (tile_y, tile_x, oc_high)
// with oc_high innermost, issuing one engine job at a time under a per-job watchdog.
module qconv_tile_scheduler #(
   parameter int TileBitWidth    = 8,
   parameter int OcHighBitWidth  = 4,
   parameter int TimeoutBitWidth = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [TileBitWidth-1:0]   cfg_tile_h_num,
   input  logic [TileBitWidth-1:0]   cfg_tile_w_num,
   input  logic [OcHighBitWidth-1:0] cfg_oc_high_num,
   output logic                      eng_start,
   input  logic                      eng_finish,
   output logic [TileBitWidth-1:0]   tile_y,
   output logic [TileBitWidth-1:0]   tile_x,
   output logic [OcHighBitWidth-1:0] oc_high,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   // Engine handshake: eng_start is a one-cycle request pulse per job; eng_finish is
   // a one-cycle completion pulse and is honoured only while waiting on that job.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_ADVANCE,
      ST_FINISH
   } state_t;

   state_t                     state_q, state_d;
   logic [TileBitWidth-1:0]    cfg_h_q, cfg_h_d;
   logic [TileBitWidth-1:0]    cfg_w_q, cfg_w_d;
   logic [OcHighBitWidth-1:0]  cfg_oc_q, cfg_oc_d;
   logic [TileBitWidth-1:0]    tile_y_q, tile_y_d;
   logic [TileBitWidth-1:0]    tile_x_q, tile_x_d;
   logic [OcHighBitWidth-1:0]  oc_high_q, oc_high_d;
   logic [TimeoutBitWidth-1:0] wd_q, wd_d;
   logic                       err_q, err_d;
   logic                       eng_start_q, eng_start_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   logic                       last_y, last_x, last_oc;
   logic [TimeoutBitWidth-1:0] wd_inc;
   logic                       cfg_bad;

   assign last_y  = (tile_y_q  == cfg_h_q  - TileBitWidth'(1));
   assign last_x  = (tile_x_q  == cfg_w_q  - TileBitWidth'(1));
   assign last_oc = (oc_high_q == cfg_oc_q - OcHighBitWidth'(1));
   assign wd_inc  = wd_q + TimeoutBitWidth'(1);
   assign cfg_bad = (cfg_tile_h_num == '0) || (cfg_tile_w_num == '0) ||
                    (cfg_oc_high_num == '0);

   always_comb begin
      state_d   = state_q;
      cfg_h_d   = cfg_h_q;
      cfg_w_d   = cfg_w_q;
      cfg_oc_d  = cfg_oc_q;
      tile_y_d  = tile_y_q;
      tile_x_d  = tile_x_q;
      oc_high_d = oc_high_q;
      wd_d      = wd_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_h_d   = cfg_tile_h_num;
               cfg_w_d   = cfg_tile_w_num;
               cfg_oc_d  = cfg_oc_high_num;
               tile_y_d  = '0;
               tile_x_d  = '0;
               oc_high_d = '0;
               err_d     = cfg_bad;
               state_d   = cfg_bad ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_finish) begin
               state_d = ST_ADVANCE;
            end else begin
               wd_d = wd_inc;
               if (wd_inc == {TimeoutBitWidth{1'b1}}) begin
                  err_d   = 1'b1;
                  state_d = ST_FINISH;
               end
            end
         end
         ST_ADVANCE: begin
            // On the final job the indices are left at their last values for the host.
            if (last_oc && last_x && last_y) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_ISSUE;
               if (!last_oc) begin
                  oc_high_d = oc_high_q + OcHighBitWidth'(1);
               end else begin
                  oc_high_d = '0;
                  if (!last_x) begin
                     tile_x_d = tile_x_q + TileBitWidth'(1);
                  end else begin
                     tile_x_d = '0;
                     tile_y_d = tile_y_q + TileBitWidth'(1);
                  end
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      eng_start_d = (state_d == ST_ISSUE);
      busy_d      = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_ADVANCE);
      done_d      = (state_d == ST_FINISH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cfg_h_q     <= '0;
         cfg_w_q     <= '0;
         cfg_oc_q    <= '0;
         tile_y_q    <= '0;
         tile_x_q    <= '0;
         oc_high_q   <= '0;
         wd_q        <= '0;
         err_q       <= 1'b0;
         eng_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_h_q     <= cfg_h_d;
         cfg_w_q     <= cfg_w_d;
         cfg_oc_q    <= cfg_oc_d;
         tile_y_q    <= tile_y_d;
         tile_x_q    <= tile_x_d;
         oc_high_q   <= oc_high_d;
         wd_q        <= wd_d;
         err_q       <= err_d;
         eng_start_q <= eng_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign eng_start = eng_start_q;
   assign tile_y    = tile_y_q;
   assign tile_x    = tile_x_q;
   assign oc_high   = oc_high_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_qconv_tile_scheduler.sv
// Scoreboard bench for qconv_tile_scheduler: expected job indices and layer
// outcomes are queued by the driver and popped by a negedge monitor.
module tb_qconv_tile_scheduler;

   localparam int TW  = 8;
   localparam int OW  = 4;
   localparam int TOW = 4;
   localparam int W   = 2 * TW + OW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [TW-1:0] cfg_tile_h_num = '0;
   logic [TW-1:0] cfg_tile_w_num = '0;
   logic [OW-1:0] cfg_oc_high_num = '0;
   logic          eng_start;
   logic          eng_finish;
   logic [TW-1:0] tile_y;
   logic [TW-1:0] tile_x;
   logic [OW-1:0] oc_high;
   logic          busy;
   logic          done;
   logic          err;
   logic          model_fin = 1'b0;
   logic          tb_fin = 1'b0;

   assign eng_finish = model_fin | tb_fin;

   qconv_tile_scheduler #(
      .TileBitWidth   (TW),
      .OcHighBitWidth (OW),
      .TimeoutBitWidth(TOW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .cfg_tile_h_num (cfg_tile_h_num),
      .cfg_tile_w_num (cfg_tile_w_num),
      .cfg_oc_high_num(cfg_oc_high_num),
      .eng_start      (eng_start),
      .eng_finish     (eng_finish),
      .tile_y         (tile_y),
      .tile_x         (tile_x),
      .oc_high        (oc_high),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   bit           done_exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int n_start = 0;
   int n_done = 0;
   int start_cyc = 0;
   int done_cyc = 0;
   int acc_cyc = 0;
   int eng_jobs = 0;
   int resp_limit = 1000000;
   int eng_delay = 5;
   bit glitch = 1'b0;

   function automatic void check(string name, int act, int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (eng_start) begin
            n_start++;
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_eng_start", 1, 0);
            end else begin
               check("job_index", int'({tile_y, tile_x, oc_high}), int'(exp_q.pop_front()));
            end
            check("busy_at_issue", int'(busy), 1);
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
            if (done_exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               check("err_at_done", int'(err), int'(done_exp_q.pop_front()));
            end
            check("busy_at_done", int'(busy), 0);
         end
      end
   end

   // ---------------- engine model ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && eng_start) begin
            eng_jobs++;
            if (eng_jobs <= resp_limit) begin
               if (glitch) begin
                  model_fin = 1'b1;
                  @(negedge clk);
                  model_fin = 1'b0;
                  repeat (eng_delay - 1) @(negedge clk);
               end else begin
                  repeat (eng_delay) @(negedge clk);
               end
               model_fin = 1'b1;
               @(negedge clk);
               model_fin = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_layer(input int h, input int w, input int oc, input int hold,
                              input bit exp_err, input bit fin_with_start);
      logic [W-1:0] t;
      @(negedge clk);
      cfg_tile_h_num  = TW'(h);
      cfg_tile_w_num  = TW'(w);
      cfg_oc_high_num = OW'(oc);
      start           = 1'b1;
      tb_fin          = fin_with_start;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            for (int o = 0; o < oc; o++) begin
               t = {TW'(y), TW'(x), OW'(o)};
               exp_q.push_back(t);
            end
      done_exp_q.push_back(exp_err);
      @(posedge clk);
      #1 acc_cyc = cyc;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         tb_fin = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int  d0;
      bit  seen;
      d0   = n_done;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (n_done != d0) seen = 1'b1;
      end
      check(name, int'(seen), 1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_eng_start"}, int'(eng_start), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_err"}, int'(err), 0);
      check({tag, "_idx"}, int'({tile_y, tile_x, oc_high}), 0);
   endtask

   // ---------------- directed sequence ----------------
   int s0;
   int s1;
   bit hit;

   initial begin
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // Full 2x3x2 layer: 12 jobs, oc_high innermost.
      s0 = n_start;
      start_layer(2, 3, 2, 1, 1'b0, 1'b0);
      wait_done(400, "t1_done_seen");
      check("t1_job_count", n_start - s0, 12);
      check("t1_queue_empty", exp_q.size(), 0);
      check("t1_idx_hold", int'({tile_y, tile_x, oc_high}), int'({8'd1, 8'd2, 4'd1}));
      @(negedge clk);
      check("t1_busy_after", int'(busy), 0);
      check("t1_done_single", int'(done), 0);
      check("t1_idx_idle_hold", int'({tile_y, tile_x, oc_high}), int'({8'd1, 8'd2, 4'd1}));

      // Single job, finish 1 cycle after eng_start; finish also raised with start in IDLE.
      eng_delay = 1;
      s0 = n_start;
      start_layer(1, 1, 1, 1, 1'b0, 1'b1);
      wait_done(50, "t2_done_seen");
      check("t2_start_latency", start_cyc - acc_cyc, 0);
      check("t2_done_latency", done_cyc - acc_cyc, 3);
      check("t2_job_count", n_start - s0, 1);
      eng_delay = 5;

      // Zero oc_high count: no job, err, immediate done; next valid start clears err.
      s0 = n_start;
      start_layer(1, 1, 0, 1, 1'b1, 1'b0);
      wait_done(10, "t3_done_seen");
      check("t3_done_latency", done_cyc - acc_cyc, 0);
      check("t3_no_job", n_start - s0, 0);
      check("t3_err_set", int'(err), 1);
      @(negedge clk);
      check("t3_err_sticky", int'(err), 1);
      start_layer(1, 1, 1, 1, 1'b0, 1'b0);
      check("t3_err_cleared", int'(err), 0);
      wait_done(50, "t3b_done_seen");

      // Hung engine: watchdog fires, later finishes ignored.
      resp_limit = eng_jobs;
      start_layer(1, 1, 1, 1, 1'b1, 1'b0);
      wait_done(60, "t4_done_seen");
      check("t4_timeout_latency", done_cyc - start_cyc, 16);
      s1 = n_start;
      @(negedge clk);
      tb_fin = 1'b1;
      repeat (3) @(negedge clk);
      tb_fin = 1'b0;
      @(negedge clk);
      check("t4_no_restart", n_start - s1, 0);
      check("t4_idle_busy", int'(busy), 0);
      check("t4_err_sticky", int'(err), 1);

      // Reset while job 5 is outstanding, then a fresh 1x2x1 layer.
      resp_limit = eng_jobs + 4;
      s0 = n_start;
      start_layer(2, 3, 2, 1, 1'b0, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk);
         if (n_start - s0 >= 5) hit = 1'b1;
      end
      check("t5_reached_job5", int'(hit), 1);
      repeat (3) @(negedge clk);
      check("t5_busy_in_wait", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("t5_reset");
      exp_q.delete();
      done_exp_q.delete();
      repeat (2) @(negedge clk);
      check_outputs_zero("t5_reset_hold");
      rst_n = 1'b1;
      resp_limit = 1000000;
      s0 = n_start;
      repeat (4) @(negedge clk);
      check("t5_no_issue_after_reset", n_start - s0, 0);
      start_layer(1, 2, 1, 1, 1'b0, 1'b0);
      wait_done(100, "t5_done_seen");
      check("t5_job_count", n_start - s0, 2);

      // start held 20 cycles mid-layer, spurious finish during every ISSUE cycle.
      glitch = 1'b1;
      s0 = n_start;
      start_layer(2, 2, 2, 20, 1'b0, 1'b0);
      wait_done(400, "t6_done_seen");
      check("t6_job_count", n_start - s0, 8);
      glitch = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_no_restart", n_start - s0, 8);

      check("final_exp_q_empty", exp_q.size(), 0);
      check("final_done_q_empty", done_exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of sequence expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule
